regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register and data port.
REQ-002 Parameter AW, default 5, register-number width; register count NREG = 2**AW.
REQ-003 Parameter ZERO_R0, default 1, when 1 register 0 is hardwired to zero.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rna, rnb  in  AW  register numbers of read ports A and B.
REQ-007 qa, qb  out  WIDTH  read data of ports A and B.
REQ-008 rdya, rdyb  out  1  operand on qa/qb is valid this cycle (not pending).
REQ-009 we0, wn0, d0  in  1/AW/WIDTH  write port 0 (integer pipeline writeback).
REQ-010 we1, wn1, d1  in  1/AW/WIDTH  write port 1 (FPU / long-latency writeback).
REQ-011 iss, iwn  in  1/AW  issue strobe; marks register iwn as pending a write.
REQ-012 busy  out  NREG  per-register pending-write scoreboard, bit i = register i.

Function
REQ-013 Storage SHALL be NREG registers of WIDTH bits plus NREG busy bits.
REQ-014 Port k write SHALL occur on the clock edge when wek=1, rst=0, and not (ZERO_R0=1 and wnk=0).
REQ-015 Both ports writing the same register in one cycle: port 1 data SHALL be stored.
REQ-016 Reads SHALL be combinational, zero-latency, with write bypass: port 1 match (we1, wn1=rn) -> d1; else port 0 match -> d0; else stored value.
REQ-017 ZERO_R0=1 and rn=0: qa/qb SHALL be 0, rdy SHALL be 1, regardless of writes or bypass.
REQ-018 Busy bit of iwn SHALL be set at the edge when iss=1 (not for r0 when ZERO_R0=1).
REQ-019 Busy bit of a register SHALL be cleared at the edge when either enabled write port targets it.
REQ-020 Issue and write to the same register in one cycle: busy SHALL end 1 (new producer wins).
REQ-021 Issue to an already-busy register: busy SHALL stay 1 and clear on the next write to it.
REQ-022 rdyX SHALL be 1 when busy[rnX]=0, or an enabled write targets rnX this cycle, else 0.
REQ-023 busy output SHALL reflect registered state only (no same-cycle bypass); bit 0 always 0 when ZERO_R0=1.
REQ-024 Write to a non-busy register SHALL be legal and update data; busy stays 0.
REQ-025 Out-of-range or X-free behaviour: all register numbers 0..NREG-1 valid, no wrap logic required.

Reset
REQ-026 rst=1 at an edge SHALL clear all registers to 0 and all busy bits to 0.
REQ-027 rst SHALL dominate writes and issues presented in the same cycle; those are discarded.
REQ-028 After reset: qa=qb=0 and rdya=rdyb=1 for any rna/rnb with no write active; busy=0.
REQ-029 Reset asserted mid-operation SHALL lose all pending scoreboard state; no late write is blocked.

Verification
REQ-030 Reset, then rna=3, rnb=0 -> qa=0, qb=0, rdya=rdyb=1, busy=0.
REQ-031 we0=1 wn0=5 d0=0x1234 with rna=5 same cycle -> qa=0x1234 (bypass); next cycle we0=0 -> qa=0x1234 (stored).
REQ-032 we0 wn0=7 d0=0xA and we1 wn1=7 d1=0xB same cycle, rna=7 -> qa=0xB that cycle and after.
REQ-033 iss iwn=9 -> next cycle busy[9]=1, rna=9 rdya=0; then we1 wn1=9 d1=0xF00D -> rdya=1, qa=0xF00D same cycle, busy[9]=0 next cycle.
REQ-034 iss iwn=4 with we0 wn0=4 same cycle -> busy[4]=1 next cycle, reg4 holds d0.
REQ-035 we0 wn0=0 d0=0xFFFF, iss iwn=0 (ZERO_R0=1) -> qa(rna=0)=0, busy[0]=0; rst with iss iwn=2 -> busy[2]=0.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write, two-read register file with pending-write scoreboard and write bypass
module regfile_sb #(
    parameter int WIDTH   = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        rna,
    input  logic [AW-1:0]        rnb,
    output logic [WIDTH-1:0]     qa,
    output logic [WIDTH-1:0]     qb,
    output logic                 rdya,
    output logic                 rdyb,
    input  logic                 we0,
    input  logic [AW-1:0]        wn0,
    input  logic [WIDTH-1:0]     d0,
    input  logic                 we1,
    input  logic [AW-1:0]        wn1,
    input  logic [WIDTH-1:0]     d1,
    input  logic                 iss,
    input  logic [AW-1:0]        iwn,
    output logic [(1<<AW)-1:0]   busy
);

    localparam int NREG = 1 << AW;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic             wr0_en;
    logic             wr1_en;
    logic             iss_en;

    function automatic logic is_r0(input logic [AW-1:0] rn);
        return (ZERO_R0 != 0) && (rn == '0);
    endfunction

    assign wr0_en = we0 && !is_r0(wn0);
    assign wr1_en = we1 && !is_r0(wn1);
    assign iss_en = iss && !is_r0(iwn);

    // Clears first, then issue: a same-cycle issue marks the new producer as pending.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) begin
            busy_d[wn0] = 1'b0;
        end
        if (wr1_en) begin
            busy_d[wn1] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iwn] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Port 1 is written last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr0_en) begin
                regs_q[wn0] <= d0;
            end
            if (wr1_en) begin
                regs_q[wn1] <= d1;
            end
            busy_q <= busy_d;
        end
    end

    function automatic logic [WIDTH-1:0] read_data(input logic [AW-1:0] rn);
        logic [WIDTH-1:0] val;
        val = regs_q[rn];
        if (is_r0(rn)) begin
            val = '0;
        end else if (we1 && (wn1 == rn)) begin
            val = d1;
        end else if (we0 && (wn0 == rn)) begin
            val = d0;
        end
        return val;
    endfunction

    function automatic logic read_ready(input logic [AW-1:0] rn);
        return is_r0(rn) || !busy_q[rn] || (we0 && (wn0 == rn)) || (we1 && (wn1 == rn));
    endfunction

    assign qa   = read_data(rna);
    assign qb   = read_data(rnb);
    assign rdya = read_ready(rna);
    assign rdyb = read_ready(rnb);
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rna, rnb, wn0, wn1, iwn;
    logic [31:0] qa, qb, d0, d1;
    logic        rdya, rdyb, we0, we1, iss;
    logic [31:0] busy;

    int n_cmp;
    int n_bad;

    regfile_sb #(.WIDTH(32), .AW(5), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst),
        .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .rdya(rdya), .rdyb(rdyb),
        .we0(we0), .wn0(wn0), .d0(d0),
        .we1(we1), .wn1(wn1), .d1(d1),
        .iss(iss), .iwn(iwn), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
        wn0 = '0; wn1 = '0; iwn = '0; d0 = '0; d1 = '0;
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rna = '0; rnb = '0;
        step();

        // Reset dominates a write and an issue in the same cycle.
        rst = 1'b1; iss = 1'b1; iwn = 5'd2; we0 = 1'b1; wn0 = 5'd3; d0 = 32'h55;
        step();
        idle();
        rna = 5'd3; rnb = 5'd0;
        #1;
        check_eq("rst_qa", qa, 32'h0);
        check_eq("rst_qb", qb, 32'h0);
        check_eq("rst_rdya", {31'b0, rdya}, 32'h1);
        check_eq("rst_rdyb", {31'b0, rdyb}, 32'h1);
        check_eq("rst_busy", busy, 32'h0);

        // Port 0 bypass, then stored value.
        step();
        we0 = 1'b1; wn0 = 5'd5; d0 = 32'h1234; rna = 5'd5;
        #1;
        check_eq("byp0_qa", qa, 32'h1234);
        check_eq("byp0_rdya", {31'b0, rdya}, 32'h1);
        step();
        idle();
        #1;
        check_eq("stored5_qa", qa, 32'h1234);

        // Same-register collision: port 1 wins in bypass and storage.
        step();
        we0 = 1'b1; wn0 = 5'd7; d0 = 32'hA; we1 = 1'b1; wn1 = 5'd7; d1 = 32'hB; rna = 5'd7;
        #1;
        check_eq("coll_byp_qa", qa, 32'hB);
        step();
        idle();
        #1;
        check_eq("coll_stored_qa", qa, 32'hB);

        // Issue then long-latency writeback on port 1.
        step();
        iss = 1'b1; iwn = 5'd9;
        step();
        idle();
        rna = 5'd9;
        #1;
        check_eq("iss9_busy", busy, 32'h0000_0200);
        check_eq("iss9_rdya", {31'b0, rdya}, 32'h0);
        step();
        we1 = 1'b1; wn1 = 5'd9; d1 = 32'hF00D;
        #1;
        check_eq("wb9_rdya", {31'b0, rdya}, 32'h1);
        check_eq("wb9_qa", qa, 32'hF00D);
        check_eq("wb9_busy_still", busy, 32'h0000_0200);
        step();
        idle();
        #1;
        check_eq("wb9_busy_clr", busy, 32'h0);
        check_eq("wb9_stored_qa", qa, 32'hF00D);

        // Issue and write to the same register: new producer wins.
        step();
        iss = 1'b1; iwn = 5'd4; we0 = 1'b1; wn0 = 5'd4; d0 = 32'h44;
        step();
        idle();
        rna = 5'd4;
        #1;
        check_eq("iw4_busy", busy, 32'h0000_0010);
        check_eq("iw4_qa", qa, 32'h44);
        check_eq("iw4_rdya", {31'b0, rdya}, 32'h0);

        // Re-issue to a busy register keeps it busy until the next write.
        step();
        iss = 1'b1; iwn = 5'd4;
        step();
        idle();
        #1;
        check_eq("reiss4_busy", busy, 32'h0000_0010);
        step();
        we0 = 1'b1; wn0 = 5'd4; d0 = 32'h45;
        step();
        idle();
        #1;
        check_eq("wr4_busy_clr", busy, 32'h0);
        check_eq("wr4_qa", qa, 32'h45);

        // Register 0 ignores writes and issues.
        step();
        we0 = 1'b1; wn0 = 5'd0; d0 = 32'hFFFF; iss = 1'b1; iwn = 5'd0; rna = 5'd0;
        #1;
        check_eq("r0_byp_qa", qa, 32'h0);
        check_eq("r0_rdya", {31'b0, rdya}, 32'h1);
        step();
        idle();
        #1;
        check_eq("r0_busy", busy, 32'h0);
        check_eq("r0_qa", qa, 32'h0);

        // Port B sees port-0 bypass; write to a non-busy register leaves busy clear.
        step();
        we0 = 1'b1; wn0 = 5'd10; d0 = 32'h1; rnb = 5'd10;
        #1;
        check_eq("pb_byp_qb", qb, 32'h1);
        check_eq("pb_rdyb", {31'b0, rdyb}, 32'h1);
        step();
        idle();
        #1;
        check_eq("pb_busy", busy, 32'h0);
        check_eq("pb_stored_qb", qb, 32'h1);

        // Reset mid-operation discards pending state and data.
        step();
        iss = 1'b1; iwn = 5'd6;
        step();
        idle();
        #1;
        check_eq("mid_busy_set", busy, 32'h0000_0040);
        step();
        rst = 1'b1;
        step();
        idle();
        rna = 5'd6; rnb = 5'd5;
        #1;
        check_eq("mid_busy_clr", busy, 32'h0);
        check_eq("mid_rdya", {31'b0, rdya}, 32'h1);
        check_eq("mid_qb_cleared", qb, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
